// File: rtl/uart_tx_fifo_if.sv
// Push-side valid/ready handshake for uart_tx_fifo.
interface uart_tx_fifo_if #(
    parameter int unsigned PAYLOAD_BITS = 8
);
    logic [PAYLOAD_BITS-1:0] tx_data;
    logic                    tx_valid;
    logic                    tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular FIFO; define UART_TX_PARITY_EN to insert
// an even-parity bit between the data bits and the stop bits.
module uart_tx_fifo #(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned BIT_RATE     = 115200,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    uart_tx_fifo_if.slave                 tx,
    output logic                          uart_txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int unsigned CYC_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(PAYLOAD_BITS);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    state_t                  state;
    logic [CYC_W-1:0]        cyc;
    logic [IDX_W-1:0]        bit_idx;
    logic [PAYLOAD_BITS-1:0] shreg;
`ifdef UART_TX_PARITY_EN
    logic                    parity_bit;
`endif
    logic                    push;
    logic                    pop;
    logic                    cyc_end;

    assign tx.tx_ready  = (count != CNT_W'(FIFO_DEPTH));
    assign busy         = (state != IDLE) || (count != '0);
    assign fifo_count   = count;
    assign push         = tx.tx_valid && tx.tx_ready;
    assign pop          = (state == IDLE) && (count != '0);
    assign cyc_end      = (cyc == CYC_W'(CYCLES_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx.tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // bit_idx doubles as the stop-bit counter while in STOP
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            cyc        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            uart_txd   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    cyc      <= '0;
                    bit_idx  <= '0;
                    if (pop) begin
                        shreg      <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^mem[rd_ptr];
`endif
                        uart_txd   <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (cyc_end) begin
                        cyc      <= '0;
                        uart_txd <= shreg[0];
                        state    <= DATA;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                DATA: begin
                    if (cyc_end) begin
                        cyc <= '0;
                        if (bit_idx == IDX_W'(PAYLOAD_BITS - 1)) begin
                            bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
                            uart_txd <= parity_bit;
                            state    <= PARITY;
`else
                            uart_txd <= 1'b1;
                            state    <= STOP;
`endif
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            shreg    <= shreg >> 1;
                            uart_txd <= shreg[1];
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cyc_end) begin
                        cyc      <= '0;
                        uart_txd <= 1'b1;
                        state    <= STOP;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
`endif
                STOP: begin
                    uart_txd <= 1'b1;
                    if (cyc_end) begin
                        cyc <= '0;
                        if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: every cycle the outputs are compared
// with a frame-timing reference model built from a word queue and a countdown.
module tb_uart_tx_fifo;
    localparam int unsigned CLK_HZ   = 1000;
    localparam int unsigned BIT_RATE = 190;
    localparam int unsigned D        = 8;
    localparam int unsigned S        = 2;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CPB      = CLK_HZ / BIT_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned P = 1;
`else
    localparam int unsigned P = 0;
`endif
    localparam int unsigned FRAME = CPB * (1 + D + P + S);

    logic clk = 1'b0;
    logic resetn;
    logic uart_txd;
    logic busy;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.PAYLOAD_BITS(D)) txif ();

    uart_tx_fifo #(
        .CLK_HZ      (CLK_HZ),
        .BIT_RATE    (BIT_RATE),
        .PAYLOAD_BITS(D),
        .STOP_BITS   (S),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .tx        (txif),
        .uart_txd  (uart_txd),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    logic [D-1:0] q[$];
    logic [D-1:0] cur;
    int unsigned  remain;
    bit           accepted;
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level implied by how far into the current frame we are.
    function automatic logic exp_txd();
        int unsigned k;
        if (remain == 0) return 1'b1;
        k = (FRAME - remain) / CPB;
        if (k == 0) return 1'b0;
        if (k <= D) return cur[k-1];
        if (P == 1 && k == D + 1) return ^cur;
        return 1'b1;
    endfunction

    task automatic tick();
        bit           do_pop;
        bit           do_push;
        logic [D-1:0] din;
        do_pop  = resetn && remain == 0 && q.size() > 0;
        do_push = resetn && txif.tx_valid && q.size() < DEPTH;
        din     = txif.tx_data;
        @(posedge clk);
        if (!resetn) begin
            q.delete();
            remain = 0;
        end else begin
            if (remain > 0) remain--;
            if (do_pop) begin
                cur    = q.pop_front();
                remain = FRAME;
            end
            if (do_push) q.push_back(din);
        end
        accepted = do_push;
        #1;
        check("txd",   uart_txd, exp_txd());
        check("count", fifo_count, q.size());
        check("ready", txif.tx_ready, q.size() < DEPTH);
        check("busy",  busy, remain > 0 || q.size() > 0);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) tick();
    endtask

    task automatic push_word(input logic [D-1:0] w);
        int unsigned guard;
        guard         = 0;
        txif.tx_valid = 1'b1;
        txif.tx_data  = w;
        accepted      = 1'b0;
        while (!accepted && guard < 8 * FRAME) begin
            tick();
            guard++;
        end
    endtask

    task automatic drain();
        int unsigned guard;
        guard = 0;
        txif.tx_valid = 1'b0;
        while ((remain > 0 || q.size() > 0) && guard < (DEPTH + 2) * (FRAME + 2)) begin
            tick();
            guard++;
        end
        idle(3);
    endtask

    initial begin
        resetn        = 1'b0;
        txif.tx_valid = 1'b0;
        txif.tx_data  = '0;
        remain        = 0;
        idle(2);
        check("rst_txd",   uart_txd, 1);
        check("rst_count", fifo_count, 0);
        check("rst_busy",  busy, 0);
        resetn = 1'b1;
        idle(3);

        // single word: line must still be high right after the push edge
        push_word(8'h41);
        txif.tx_valid = 1'b0;
        check("lat_high", uart_txd, 1);
        tick();
        check("lat_start", uart_txd, 0);
        drain();

        // fill: valid held high across consecutive words
        for (int i = 0; i < 5; i++) push_word(8'h31 + 8'(i));
        check("fill_count", fifo_count, 4);
        check("fill_ready", txif.tx_ready, 0);
        push_word(8'h36);
        drain();

        // edge data patterns
        push_word(8'h00);
        push_word(8'hFF);
        push_word(8'h03);
        push_word(8'h07);
        drain();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            txif.tx_valid = ($urandom_range(0, 2) == 0);
            txif.tx_data  = D'($urandom);
            tick();
        end
        drain();

        // reset during data bit 3 with two words queued
        push_word(8'h00);
        push_word(8'h5A);
        push_word(8'hA5);
        txif.tx_valid = 1'b0;
        for (int g = 0; g < 2 * FRAME && (remain == 0 || (FRAME - remain) / CPB < 4); g++) tick();
        resetn = 1'b0;
        tick();
        check("mid_rst_txd",   uart_txd, 1);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_busy",  busy, 0);
        tick();
        resetn = 1'b1;
        idle(2 * FRAME);
        check("post_rst_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO. It serialises bytes or words onto a single TX line with configurable payload width, stop-bit count and FIFO depth. It is the transmit counterpart to the receive path in `impl_top`, and replaces ad-hoc bit-banging of the serial line with synthesisable RTL. A valid/ready push interface feeds it, and its output drives the board UART TX pin directly or the `uart_rxd` of another instance in loopback benches.

## Interface
- `CLK_HZ`, 50000000: system clock frequency in Hz.
- `BIT_RATE`, 115200: line rate in bits/s; `CYCLES_PER_BIT = CLK_HZ / BIT_RATE`, integer division, truncated.
- `PAYLOAD_BITS`, 8: data bits per frame; legal range 5..9.
- `STOP_BITS`, 1: stop bits per frame; legal values 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries; must be a power of two, ≥ 2.

- `clk`, in, 1: system clock; all logic on the rising edge.
- `resetn`, in, 1: synchronous, active-low reset.
- `tx_data`, in, `PAYLOAD_BITS`: word to transmit.
- `tx_valid`, in, 1: `tx_data` is valid.
- `tx_ready`, out, 1: FIFO can accept a word; equals `!full`.
- `uart_txd`, out, 1: serial line; idles high.
- `busy`, out, 1: a frame is in progress or the FIFO is non-empty.
- `fifo_count`, out, `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation
- Push: a word is written on any rising edge where `tx_valid && tx_ready`. `tx_valid` is ignored while `tx_ready` is low, and the held word is not lost.
- FIFO: circular buffer with wrapping read and write pointers and an explicit count. A push and a pop on the same edge leave the count unchanged. Full means count equals `FIFO_DEPTH`. Empty means count is 0.
- FSM states: IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
  - IDLE: `uart_txd`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `uart_txd`=0 for `CYCLES_PER_BIT` cycles, then go to DATA.
  - DATA: shift out `PAYLOAD_BITS` bits, LSB first, each held `CYCLES_PER_BIT` cycles. Then go to PARITY if present, otherwise STOP.
  - PARITY: one bit period, then go to STOP.
  - STOP: `uart_txd`=1 for `STOP_BITS * CYCLES_PER_BIT` cycles, then go to IDLE.
- Counters: the bit-period counter runs 0..`CYCLES_PER_BIT-1` and wraps. The bit index counter runs 0..`PAYLOAD_BITS-1`.
- Back-to-back frames: if the FIFO is non-empty when STOP ends, IDLE pops on the next edge. The resulting inter-frame gap is exactly one clock of extra idle.
- `busy` = (state != IDLE) || (count != 0).

## Timing
- Reset values: `uart_txd`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0, state IDLE, pointers and counters 0.
- Latency: a word pushed on edge N into an empty FIFO while in IDLE is popped on edge N+1. `uart_txd` falls after edge N+1.
- Frame length in clocks: `CYCLES_PER_BIT * (1 + PAYLOAD_BITS + P + STOP_BITS)`, where P is 1 with parity and 0 without.
- All outputs are registered except `tx_ready` and `busy`. These two are combinational from registered state only.
- Reset mid-frame: on the edge with `resetn`=0, `uart_txd` returns to 1, the FIFO is flushed and the partial frame is abandoned. No glitch low occurs after that edge.
- Push while full: no write and no pointer change. This holds even if a pop occurs on the same edge, because `tx_ready` was low in that cycle.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in. One bit is inserted after the data bits, equal to the even parity of the payload (XOR of all data bits), so the total count of 1s across data and parity is even.
- Undefined: there is no PARITY state, and the frame is start, data, stop.

## Test plan
- Single byte 0x41, defaults (434 cycles/bit), no parity: `uart_txd` falls one clock after the push. The line is then 0 (start), 1,0,0,0,0,0,1,0, then 1 (stop), each bit 434 cycles. `busy` deasserts after 4340 cycles.
- Fill FIFO (depth 4) with `tx_valid` held high, data 0x31..0x36: 0x31..0x35 are accepted on consecutive edges, the first being popped immediately. `tx_ready` then drops with `fifo_count`=4. 0x36 is accepted one clock after the 0x31 frame ends. Output order is 0x31..0x36 with one idle clock between frames.
- `UART_TX_PARITY_EN` defined, bytes 0x03 then 0x07: parity bits are 0 and 1 respectively, and each frame is 11 bit periods.
- `PAYLOAD_BITS`=7, `STOP_BITS`=2, word 0x55: 7 data bits 1,0,1,0,1,0,1, then the stop high for 868 cycles before the next start.
- Reset pulse (`resetn`=0 for 2 clocks) during bit 3 of 0x00 with 2 words queued: `uart_txd`=1 after the reset edge, `fifo_count`=0, `busy`=0. No further frames are emitted.
- Loopback into `impl_top` `uart_rxd` at `BIT_RATE`=11520: "A","1","B","2" are sent via the FIFO, and the receiver reproduces the same four bytes.
